// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: state type, FIPS-197 S-box table, FSM encoding
// and ShiftRows helper, reused by the round datapath and key expansion.
package aes_pkg;

    localparam int NUM_COLS = 4;

    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte i sits MSB-first; byte(r,c) has index r + 4c.
    function automatic logic [7:0] get_byte(input state_t s, input int idx);
        return s[127 - 8*idx -: 8];
    endfunction

    function automatic state_t shift_rows(input state_t s);
        state_t res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8*(r + 4*c) -: 8] = get_byte(s, r + 4*((c + r) % 4));
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES forward S-box lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);

    assign y = SBOX[x];

endmodule

// File: rtl/aes_sub_shift.sv
// Iterative SubBytes (one column per clock through four shared S-boxes)
// followed by ShiftRows, with a last-round flag carried alongside the state.
//
// state | meaning
// IDLE  | waiting for a state, in_ready high
// SUB   | substituting column col_cnt of work, in_ready low
// DONE  | result on out, out_valid high for this one cycle, may accept again
module aes_sub_shift
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    input  logic         last_round_in,
    output logic [127:0] out,
    output logic         out_valid,
    output logic         last_round_out
);

    localparam int CNT_W = $clog2(NUM_COLS);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLS - 1);

    fsm_t             state;
    fsm_t             state_nxt;
    logic [CNT_W-1:0] col_cnt;
    state_t           work;
    logic             flag_q;
    logic             accept;
    logic             last_col;
    logic [31:0]      col_word;
    logic [31:0]      sub_word;
    state_t           work_sub;

    assign in_ready  = (state != SUB);
    assign accept    = in_valid & in_ready;
    assign last_col  = (state == SUB) && (col_cnt == LAST_COL);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SUB;
            SUB:  if (last_col) state_nxt = DONE;
            DONE: state_nxt = accept ? SUB : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        col_word = work[127:96];
        case (col_cnt)
            2'd0:    col_word = work[127:96];
            2'd1:    col_word = work[95:64];
            2'd2:    col_word = work[63:32];
            default: col_word = work[31:0];
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_sbox
        aes_sbox u_sbox (
            .x (col_word[31 - 8*k -: 8]),
            .y (sub_word[31 - 8*k -: 8])
        );
    end

    always_comb begin
        work_sub = work;
        case (col_cnt)
            2'd0:    work_sub[127:96] = sub_word;
            2'd1:    work_sub[95:64]  = sub_word;
            2'd2:    work_sub[63:32]  = sub_word;
            default: work_sub[31:0]   = sub_word;
        endcase
    end

    // out and last_round_out only move on completion, so they stay stable
    // through a following SUB pass for the downstream MixColumns stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt        <= '0;
            work           <= '0;
            flag_q         <= 1'b0;
            out            <= '0;
            last_round_out <= 1'b0;
        end else if (accept) begin
            col_cnt <= '0;
            work    <= in;
            flag_q  <= last_round_in;
        end else if (state == SUB) begin
            col_cnt <= col_cnt + 1'b1;
            work    <= work_sub;
            if (last_col) begin
                out            <= shift_rows(work_sub);
                last_round_out <= flag_q;
            end
        end
    end

endmodule
